// File: rtl/svm_pkg.sv
// svm_pkg: shared constants and types for the SVM batch scheduler.
// Holds the engine geometry (feature/result widths, support vector count,
// batch size), derived widths, the vector/result types and the FSM state enum.
package svm_pkg;

  localparam int DATA_SIZE  = 32;
  localparam int ACCUM_SIZE = 64;
  localparam int NUM_FEAT   = 2;
  localparam int NUM_SV     = 3;
  localparam int NUM_INST   = 2;
  localparam int FIFO_DEPTH = 4;   // power of two, >= NUM_INST

  localparam int VEC_W  = NUM_FEAT * DATA_SIZE;
  localparam int RES_W  = NUM_INST * ACCUM_SIZE;
  localparam int IDX_W  = (NUM_INST > 1) ? $clog2(NUM_INST) : 1;
  // Wide enough to hold a vector count 0..NUM_INST inclusive.
  localparam int KW     = $clog2(NUM_INST + 1);
  localparam int SV_W   = (NUM_SV > 1) ? $clog2(NUM_SV) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  typedef logic [NUM_FEAT-1:0][DATA_SIZE-1:0] vec_t;
  typedef logic [ACCUM_SIZE-1:0]              res_t;
  typedef logic [NUM_INST-1:0][ACCUM_SIZE-1:0] res_arr_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} sched_state_t;

endpackage

// File: rtl/svm_vec_fifo.sv
// svm_vec_fifo: synchronous FIFO for buffered test vectors.
// Ports: clk/rst (sync, active-high), i_push/i_wdata write side,
// i_pop read side with o_rdata showing the head entry combinationally,
// o_full/o_empty/o_count status. Push while full and pop while empty are
// dropped. DEPTH must be a power of two so the pointers wrap naturally.
module svm_vec_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/svm_batch_sched.sv
// svm_batch_sched: batch scheduler in front of the SVM systolic engine.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_vector input
// stream; flush issues a zero-padded partial batch; out_valid/out_ready/
// out_result/out_index/out_last result stream; busy; eng_start/
// eng_last_input/eng_test_vector drive the engine; eng_done/eng_results
// return the engine's result array.
//
// state | meaning
// IDLE  | waiting for a full batch in the FIFO or a flush
// ISSUE | driving NUM_INST vectors, NUM_SV cycles each
// WAIT  | waiting for eng_done
// OUT   | streaming real_n results out in input order
module svm_batch_sched
  import svm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [VEC_W-1:0]     in_vector,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACCUM_SIZE-1:0] out_result,
  output logic [IDX_W-1:0]     out_index,
  output logic                 out_last,
  output logic                 busy,
  output logic                 eng_start,
  output logic                 eng_last_input,
  output logic [VEC_W-1:0]     eng_test_vector,
  input  logic                 eng_done,
  input  logic [RES_W-1:0]     eng_results
);

  localparam logic [CNT_W-1:0] BATCH_CNT = CNT_W'(NUM_INST);
  localparam logic [KW-1:0]    K_FULL    = KW'(NUM_INST);
  localparam logic [KW-1:0]    K_LAST    = KW'(NUM_INST - 1);
  localparam logic [SV_W-1:0]  SV_LAST   = SV_W'(NUM_SV - 1);

  sched_state_t     r_state;
  logic [KW-1:0]    r_real_n;
  logic [KW-1:0]    r_k;
  logic [SV_W-1:0]  r_sv_cnt;
  logic [IDX_W-1:0] r_out_idx;
  res_arr_t         r_res;
  logic             r_out_valid;
  res_t             r_out_result;
  logic             r_out_last;
  logic             r_eng_start;
  logic             r_eng_last;
  vec_t             r_eng_vec;

  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  vec_t             w_head;
  logic             w_pop;
  logic             w_go;
  logic             w_batch_full;
  logic [KW-1:0]    w_k_next;
  logic             w_k_real;
  logic [IDX_W-1:0] w_out_next;

  svm_vec_fifo #(
    .WIDTH (VEC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (in_valid),
    .i_wdata (in_vector),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_batch_full = (w_count >= BATCH_CNT);
  assign w_go         = w_batch_full || (flush && !w_empty);
  assign w_k_next     = r_k + 1'b1;
  assign w_k_real     = (w_k_next < r_real_n);
  assign w_out_next   = r_out_idx + 1'b1;

  // Each vector leaves the FIFO on the edge that loads it into r_eng_vec;
  // padding slots beyond real_n never pop.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      IDLE:    w_pop = w_go;
      ISSUE:   w_pop = (r_sv_cnt == '0) && (r_k != K_LAST) && w_k_real;
      default: w_pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_real_n     <= K_FULL;
      r_k          <= '0;
      r_sv_cnt     <= '0;
      r_out_idx    <= '0;
      r_res        <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_last   <= 1'b0;
      r_eng_start  <= 1'b0;
      r_eng_last   <= 1'b0;
      r_eng_vec    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_go) begin
            r_state     <= ISSUE;
            r_real_n    <= w_batch_full ? K_FULL : KW'(w_count);
            r_k         <= '0;
            r_sv_cnt    <= SV_LAST;
            r_eng_start <= 1'b1;
            r_eng_last  <= (NUM_INST == 1);
            r_eng_vec   <= w_head;
          end
        end
        ISSUE: begin
          r_eng_start <= 1'b0;
          r_eng_last  <= 1'b0;
          if (r_sv_cnt != '0) begin
            r_sv_cnt <= r_sv_cnt - 1'b1;
          end else if (r_k == K_LAST) begin
            r_state   <= WAIT;
            r_eng_vec <= '0;
          end else begin
            r_k        <= w_k_next;
            r_sv_cnt   <= SV_LAST;
            r_eng_vec  <= w_k_real ? w_head : '0;
            r_eng_last <= (w_k_next == K_LAST);
          end
        end
        WAIT: begin
          if (eng_done) begin
            r_state      <= OUT;
            r_res        <= eng_results;
            r_out_valid  <= 1'b1;
            r_out_result <= eng_results[ACCUM_SIZE-1:0];
            r_out_idx    <= '0;
            r_out_last   <= (r_real_n == KW'(1));
          end
        end
        OUT: begin
          if (r_out_valid && out_ready) begin
            if (r_out_last) begin
              r_state      <= IDLE;
              r_out_valid  <= 1'b0;
              r_out_result <= '0;
              r_out_idx    <= '0;
              r_out_last   <= 1'b0;
            end else begin
              r_out_idx    <= w_out_next;
              r_out_result <= r_res[w_out_next];
              r_out_last   <= (KW'(w_out_next) == (r_real_n - 1'b1));
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready        = !w_full;
  assign busy            = (r_state != IDLE) || !w_empty;
  assign out_valid       = r_out_valid;
  assign out_result      = r_out_result;
  assign out_index       = r_out_idx;
  assign out_last        = r_out_last;
  assign eng_start       = r_eng_start;
  assign eng_last_input  = r_eng_last;
  assign eng_test_vector = r_eng_vec;

endmodule

// File: tb/tb_svm_batch_sched.sv
// Directed testbench for svm_batch_sched with hand-computed expectations.
module tb_svm_batch_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_vector;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_result;
  logic [0:0]   out_index;
  logic         out_last;
  logic         busy;
  logic         eng_start;
  logic         eng_last_input;
  logic [63:0]  eng_test_vector;
  logic         eng_done;
  logic [127:0] eng_results;

  int n_tests = 0;
  int n_fail  = 0;
  logic seen_valid;

  always #5 clk = ~clk;

  svm_batch_sched dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_vector       (in_vector),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_result      (out_result),
    .out_index       (out_index),
    .out_last        (out_last),
    .busy            (busy),
    .eng_start       (eng_start),
    .eng_last_input  (eng_last_input),
    .eng_test_vector (eng_test_vector),
    .eng_done        (eng_done),
    .eng_results     (eng_results)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] vec(input int a, input int b);
    return {b[31:0], a[31:0]};
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"},  in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_result"}, out_result, 0);
    chk({tag, "_out_index"}, out_index, 0);
    chk({tag, "_out_last"},  out_last, 0);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_eng_start"}, eng_start, 0);
    chk({tag, "_eng_last"},  eng_last_input, 0);
    chk({tag, "_eng_vec"},   eng_test_vector, 0);
  endtask

  // Called on the first ISSUE cycle; returns on the first WAIT cycle.
  // in_valid is dropped after the first edge so a pending push lands once.
  task automatic chk_issue(input logic [63:0] e0, input logic [63:0] e1);
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 3; s++) begin
        chk("iss_start", eng_start, (k == 0 && s == 0));
        chk("iss_last",  eng_last_input, (k == 1 && s == 0));
        chk("iss_vec",   eng_test_vector, (k == 0) ? e0 : e1);
        chk("iss_valid", out_valid, 0);
        tick();
        in_valid = 1'b0;
      end
    end
    chk("wait_vec",   eng_test_vector, 0);
    chk("wait_start", eng_start, 0);
    chk("wait_busy",  busy, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_vector = '0; flush = 1'b0;
    out_ready = 1'b1; eng_done = 1'b0; eng_results = '0;
    tick(); tick();
    chk_reset("rst");
    rst = 1'b0;

    // flush with empty FIFO and eng_done in IDLE are ignored
    flush = 1'b1; eng_done = 1'b1; eng_results = {64'h77, 64'h66};
    tick();
    flush = 1'b0; eng_done = 1'b0;
    chk("idle_flush_busy",  busy, 0);
    chk("idle_flush_start", eng_start, 0);
    chk("idle_done_valid",  out_valid, 0);
    tick();
    chk("idle_still_start", eng_start, 0);

    // batch 1: full
    in_valid = 1'b1; in_vector = vec(1, 2); tick();
    in_vector = vec(3, 4); tick();
    in_valid = 1'b0;
    chk("c0_busy",  busy, 1);
    chk("c0_start", eng_start, 0);
    tick();
    chk_issue(vec(1, 2), vec(3, 4));

    // fill FIFO during WAIT; eng_done on the 4th push cycle
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_vector = vec(10 + 2 * i, 11 + 2 * i);
      chk("fill_ready", in_ready, 1);
      if (i == 3) begin
        eng_done = 1'b1; eng_results = {64'hB, 64'hA};
      end
      tick();
    end
    eng_done = 1'b0;
    in_vector = vec(18, 19);
    chk("full_ready",  in_ready, 0);
    chk("b1_valid0",   out_valid, 1);
    chk("b1_res0",     out_result, 64'hA);
    chk("b1_idx0",     out_index, 0);
    chk("b1_last0",    out_last, 0);
    tick();
    chk("full_ready2", in_ready, 0);
    chk("b1_valid1",   out_valid, 1);
    chk("b1_res1",     out_result, 64'hB);
    chk("b1_idx1",     out_index, 1);
    chk("b1_last1",    out_last, 1);
    tick();
    chk("b1_drop",     out_valid, 0);
    chk("full_ready3", in_ready, 0);
    chk("b1_busy",     busy, 1);
    tick();
    chk("pop_ready",   in_ready, 1);
    chk_issue(vec(10, 11), vec(12, 13));
    chk("b2_ready",    in_ready, 1);

    // batch 2 with backpressure
    eng_done = 1'b1; eng_results = {64'hD, 64'hC}; out_ready = 1'b0;
    tick();
    eng_done = 1'b0;
    chk("bp_valid", out_valid, 1);
    chk("bp_res",   out_result, 64'hC);
    chk("bp_idx",   out_index, 0);
    chk("bp_last",  out_last, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_res",   out_result, 64'hC);
      chk("bp_hold_idx",   out_index, 0);
    end
    out_ready = 1'b1;
    tick();
    chk("b2_res1",  out_result, 64'hD);
    chk("b2_idx1",  out_index, 1);
    chk("b2_last1", out_last, 1);
    chk("b2_valid1", out_valid, 1);
    tick();
    chk("b2_drop", out_valid, 0);
    tick();
    chk_issue(vec(14, 15), vec(16, 17));

    // batch 3
    eng_done = 1'b1; eng_results = {64'hF, 64'hE};
    tick();
    eng_done = 1'b0;
    chk("b3_res0",  out_result, 64'hE);
    chk("b3_last0", out_last, 0);
    tick();
    chk("b3_res1",  out_result, 64'hF);
    chk("b3_idx1",  out_index, 1);
    chk("b3_last1", out_last, 1);
    tick();
    chk("b3_drop",  out_valid, 0);
    chk("b3_busy",  busy, 1);
    tick();
    chk("one_no_start", eng_start, 0);
    chk("one_busy",     busy, 1);

    // partial flush of the single remaining vector
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_issue(vec(18, 19), 64'h0);
    eng_done = 1'b1; eng_results = {64'h99, 64'h55};
    tick();
    eng_done = 1'b0;
    chk("pf_valid", out_valid, 1);
    chk("pf_res",   out_result, 64'h55);
    chk("pf_idx",   out_index, 0);
    chk("pf_last",  out_last, 1);
    tick();
    chk("pf_drop",  out_valid, 0);
    chk("pf_busy",  busy, 0);

    // spurious eng_done in ISSUE, then reset mid-ISSUE
    in_valid = 1'b1; in_vector = vec(5, 6); tick();
    in_vector = vec(7, 8); tick();
    in_valid = 1'b0;
    tick();
    chk("r_start", eng_start, 1);
    chk("r_vec",   eng_test_vector, vec(5, 6));
    eng_done = 1'b1; eng_results = {64'h1, 64'h2};
    tick();
    eng_done = 1'b0;
    chk("spur_valid", out_valid, 0);
    chk("spur_vec",   eng_test_vector, vec(5, 6));
    chk("spur_start", eng_start, 0);
    tick();
    chk("c3_vec", eng_test_vector, vec(5, 6));
    rst = 1'b1;
    tick();
    chk_reset("midrst");
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid || eng_start) seen_valid = 1'b1;
    end
    chk("post_rst_quiet", seen_valid, 0);
    chk("post_rst_busy",  busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
